adder_share_arbiter: RTL
========================

Name: adder_share_arbiter

Overview:
- Shares one 32-bit adder (adder_32 instance) among NREQ requesters, e.g. PC+4, branch-target and address-generation paths.
- Round-robin arbitration with valid/ready handshake on each request port.
- One registered response port carrying the sum and the winning requester ID.
- Sits between the fetch/decode control and any datapath stage that needs an add but has no dedicated adder.

Parameters:
- NREQ, 4, number of requester ports (2..8)
- IDW, 2, width of requester ID; must equal clog2(NREQ)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  reset; one clock; reset is synchronous and active-low
- req_valid  input  NREQ  per-requester request valid
- req_ready  output  NREQ  per-requester accept, one-hot or zero
- req_a  input  NREQ*32  packed operand A, requester i at bits [32i+31:32i]
- req_b  input  NREQ*32  packed operand B, same packing
- rsp_valid  output  1  response holds a valid sum
- rsp_ready  input  1  consumer accepts response
- rsp_sum  output  32  registered A+B mod 2^32
- rsp_id  output  IDW  index of requester that produced rsp_sum

Behaviour:
- Reset (rst_n=0 at a rising clk edge):
  - state=IDLE, rsp_valid=0, rsp_sum=0, rsp_id=0.
  - RR pointer=0, so requester 0 has highest priority.
  - req_ready=0 while rst_n=0.
- Grant-enable is combinational: can_accept = (state==IDLE) | (state==HOLD & rsp_ready).
- Arbitration is combinational:
  - winner = first i with req_valid[i]=1, scanning from ptr upward and wrapping modulo NREQ.
  - req_ready[winner]=1 only when can_accept=1; all other req_ready bits are 0.
  - req_ready never depends on the requester's own operands.
- Transfer occurs when req_valid[i] & req_ready[i] at a clk edge. At that edge:
  - rsp_sum <= adder_32(req_a[i], req_b[i]); carry-out is discarded, 32-bit wrap.
  - rsp_id <= i.
  - rsp_valid <= 1.
  - ptr <= (i+1) mod NREQ.
  - state <= HOLD.
- Latency: exactly 1 cycle from transfer edge to rsp_valid=1.
- Throughput: 1 add per cycle while rsp_ready=1 (HOLD->HOLD with a new grant).
- State transitions:
  - IDLE: no valid -> IDLE, outputs unchanged, rsp_valid=0. Any valid -> transfer, go to HOLD.
  - HOLD, rsp_ready=0: stay in HOLD. rsp_sum, rsp_id and rsp_valid are stable; no grant.
  - HOLD, rsp_ready=1, a request valid: transfer the new winner, stay in HOLD.
  - HOLD, rsp_ready=1, no request valid: rsp_valid <= 0, go to IDLE. rsp_sum and rsp_id keep their last values.
- Pointer moves only on a transfer; idle cycles do not rotate priority.
- Requester i deasserting req_valid before it is granted is legal: it simply drops out of arbitration.
- Requester operands must stay stable while req_valid=1 and not yet granted. The arbiter samples them only on the transfer edge.
- Reset asserted mid-HOLD discards the pending response: rsp_valid=0 on the next cycle, no grant during reset.
- With a single requester holding req_valid=1 and rsp_ready=1, it is granted every cycle (pointer wrap never starves a lone requester).

Decomposition:
- Shared package adder_arb_pkg holds:
  - state encoding constants ST_IDLE=1'b0, ST_HOLD=1'b1
  - the operand width constant DW=32
- One sub-module: rr_pick (combinational round-robin priority picker).
  - Inputs: req vector, ptr. Outputs: one-hot grant, binary index, any.
  - Reusable by a future register-port arbiter.
- adder_32 is instantiated as-is for the add; no duplicate "+" in this block.

Test Plan:
- Reset, then req_valid=0001 with req_a[0]=0x0040_0000, req_b[0]=4, rsp_ready=1 -> req_ready=0001 in cycle 0; next cycle rsp_valid=1, rsp_sum=0x0040_0004, rsp_id=0.
- Wrap: req_a[2]=0xFFFF_FFFF, req_b[2]=2 alone -> rsp_sum=0x0000_0001, rsp_id=2, no carry visible.
- Fairness: all four valid continuously, rsp_ready=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one response per cycle with matching rsp_id.
- Backpressure: response pending, rsp_ready=0 for 3 cycles with req_valid=1111 -> req_ready=0000 throughout, rsp_sum/rsp_id/rsp_valid stable; rsp_ready=1 -> next grant goes to the pointer winner.
- Drain: HOLD, rsp_ready=1, no requests -> rsp_valid=0 next cycle, state IDLE, rsp_sum retains its last value.
- Reset mid-HOLD: rsp_valid=1, drive rst_n=0 for one edge -> rsp_valid=0, ptr=0; after release, valid=1010 -> requester 1 granted first.

Source files
------------

// File: rtl/adder_arb_pkg.sv
// Shared constants and types for the shared-adder arbiter.
package adder_arb_pkg;

    // Operand and sum width of the shared adder.
    localparam int unsigned DW = 32;

    // Arbiter FSM: IDLE has no response pending, HOLD presents a response.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } arb_state_e;

endpackage

// File: rtl/adder_32.sv
// Plain 32-bit adder. The sum wraps modulo 2^32 and no carry-out is produced.
module adder_32
    import adder_arb_pkg::*;
(
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    output logic [DW-1:0] o_sum
);

    // Modular add; the carry out of the top bit is intentionally dropped.
    always_comb begin
        o_sum = i_a + i_b;
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first set request scanning upward
// from i_ptr, wrapping modulo N, wins.
module rr_pick #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = 2
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_grant,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    // Scan offsets from farthest to nearest so the nearest set request wins.
    always_comb begin
        logic [IDW-1:0] w_j;
        w_j     = '0;
        o_grant = '0;
        o_idx   = '0;
        o_any   = |i_req;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            w_j = IDW'((int'(i_ptr) + k) % int'(N));
            if (i_req[w_j]) begin
                o_grant      = '0;
                o_grant[w_j] = 1'b1;
                o_idx        = w_j;
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one 32-bit adder among NREQ requesters with round-robin arbitration
// and a single registered response port (sum plus winning requester ID).
module adder_share_arbiter
    import adder_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DW-1:0]     rsp_sum,
    output logic [IDW-1:0]    rsp_id
);

    arb_state_e     r_state, w_state_nxt;
    logic [IDW-1:0] r_ptr, w_ptr_nxt;
    logic           r_valid, w_valid_nxt;
    logic [DW-1:0]  r_sum, w_sum_nxt;
    logic [IDW-1:0] r_id, w_id_nxt;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_idx;
    logic            w_any;
    logic            w_can_accept;
    logic            w_xfer;
    logic [DW-1:0]   w_a_arr [NREQ];
    logic [DW-1:0]   w_b_arr [NREQ];
    logic [DW-1:0]   w_a, w_b, w_add;

    rr_pick #(
        .N   (NREQ),
        .IDW (IDW)
    ) u_rr_pick (
        .i_req   (req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // Unpack operand buses and select the winner's operands.
    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            w_a_arr[i] = req_a[i*DW +: DW];
            w_b_arr[i] = req_b[i*DW +: DW];
        end
        w_a = w_a_arr[w_idx];
        w_b = w_b_arr[w_idx];
    end

    adder_32 u_adder_32 (
        .i_a   (w_a),
        .i_b   (w_b),
        .o_sum (w_add)
    );

    // Grant only when the response slot is free or being drained this cycle;
    // never grant while reset is held.
    always_comb begin
        w_can_accept = rst_n & ((r_state == ST_IDLE) | ((r_state == ST_HOLD) & rsp_ready));
        req_ready    = {NREQ{w_can_accept}} & w_grant;
        w_xfer       = w_can_accept & w_any;
    end

    // Next-state logic: load a new response on transfer, drop to IDLE on drain.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_valid_nxt = r_valid;
        w_sum_nxt   = r_sum;
        w_id_nxt    = r_id;
        if (w_xfer) begin
            w_state_nxt = ST_HOLD;
            w_valid_nxt = 1'b1;
            w_sum_nxt   = w_add;
            w_id_nxt    = w_idx;
            w_ptr_nxt   = IDW'((int'(w_idx) + 1) % int'(NREQ));
        end else if ((r_state == ST_HOLD) && rsp_ready) begin
            w_state_nxt = ST_IDLE;
            w_valid_nxt = 1'b0;
        end
    end

    // State and response registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_valid <= 1'b0;
            r_sum   <= '0;
            r_id    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_valid <= w_valid_nxt;
            r_sum   <= w_sum_nxt;
            r_id    <= w_id_nxt;
        end
    end

    // Drive response outputs straight from the registers.
    always_comb begin
        rsp_valid = r_valid;
        rsp_sum   = r_sum;
        rsp_id    = r_id;
    end

endmodule
